seq_multplr_controller: RTL and testbench

FSM that sequences the 4-bit sequential multiplier datapath: load operands, conditional add, shift, repeat per bit. It drives the datapath's enable and operation bits from a start/done handshake. It sits beside the datapath under a multiplier top level and observes the datapath's lsb_b and q_b. Optional early exit when the remaining multiplier bits are zero.

---
 rtl/seq_multplr_pkg.sv | 20 ++
 rtl/seq_multplr_controller.sv | 106 ++++++++++
 tb/tb_seq_multplr_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multplr_pkg.sv
// Shared definitions for the 4-bit sequential multiplier: controller state
// encoding and datapath operation-select values.
package seq_multplr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Register A/B op select
    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_SHIFT = 1'b1;
    // Register P op select
    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_ADD   = 1'b1;

endpackage

// File: rtl/seq_multplr_controller.sv
// Sequencing FSM for the shift-and-add multiplier: LOAD, then WIDTH
// EVAL/SHIFT pairs (optionally cut short once B has no bits left), then DONE.
module seq_multplr_controller
    import seq_multplr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b0,
    localparam int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             lsb_b,
    input  logic [WIDTH-1:0] q_b,
    output logic             en_a,
    output logic             ld_shift_a,
    output logic             en_b,
    output logic             ld_shift_b,
    output logic             en_p,
    output logic             ld_add_p,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt_next;
    logic             b_rest_zero;

    // Bits of B above the LSB are all zero, so no further add can occur
    assign b_rest_zero = ((q_b >> 1) == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = bit_cnt;
        en_a       = 1'b0;
        ld_shift_a = OP_LOAD;
        en_b       = 1'b0;
        ld_shift_b = OP_LOAD;
        en_p       = 1'b0;
        ld_add_p   = OP_CLEAR;
        done       = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                en_a       = 1'b1;
                ld_shift_a = OP_LOAD;
                en_b       = 1'b1;
                ld_shift_b = OP_LOAD;
                en_p       = 1'b1;
                ld_add_p   = OP_CLEAR;
                cnt_next   = '0;
                next_state = EVAL;
            end
            EVAL: begin
                en_p       = lsb_b;
                ld_add_p   = OP_ADD;
                next_state = SHIFT;
            end
            SHIFT: begin
                en_a       = 1'b1;
                ld_shift_a = OP_SHIFT;
                en_b       = 1'b1;
                ld_shift_b = OP_SHIFT;
                cnt_next   = bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(WIDTH - 1))
                    next_state = DONE;
                else if (EARLY_EXIT && b_rest_zero)
                    next_state = DONE;
                else
                    next_state = EVAL;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Cancel wins over everything, including the DONE pulse's successor
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
            cnt_next   = '0;
        end
    end

endmodule

// File: tb/tb_seq_multplr_controller.sv
// Bench: two controllers (early exit off/on) each driving a behavioural
// shift-and-add datapath, checked against hand-computed products and latencies.
module tb_seq_multplr_controller;

    logic       clk = 1'b0;
    logic       clr, start, abort;
    logic [3:0] opa, opb;

    logic       en_a0, ld_shift_a0, en_b0, ld_shift_b0, en_p0, ld_add_p0, busy0, done0;
    logic [2:0] bit_cnt0;
    logic       en_a1, ld_shift_a1, en_b1, ld_shift_b1, en_p1, ld_add_p1, busy1, done1;
    logic [2:0] bit_cnt1;

    logic [7:0] ra0, rp0, ra1, rp1;
    logic [3:0] rb0, rb1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_multplr_controller #(.WIDTH(4), .EARLY_EXIT(1'b0)) u0 (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .lsb_b(rb0[0]), .q_b(rb0),
        .en_a(en_a0), .ld_shift_a(ld_shift_a0), .en_b(en_b0), .ld_shift_b(ld_shift_b0),
        .en_p(en_p0), .ld_add_p(ld_add_p0), .busy(busy0), .done(done0), .bit_cnt(bit_cnt0)
    );

    seq_multplr_controller #(.WIDTH(4), .EARLY_EXIT(1'b1)) u1 (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .lsb_b(rb1[0]), .q_b(rb1),
        .en_a(en_a1), .ld_shift_a(ld_shift_a1), .en_b(en_b1), .ld_shift_b(ld_shift_b1),
        .en_p(en_p1), .ld_add_p(ld_add_p1), .busy(busy1), .done(done1), .bit_cnt(bit_cnt1)
    );

    // Datapath models: A shifts left, B shifts right, P accumulates A
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            ra0 <= 8'd0; rb0 <= 4'd0; rp0 <= 8'd0;
        end else begin
            if (en_a0) ra0 <= ld_shift_a0 ? {ra0[6:0], 1'b0} : {4'd0, opa};
            if (en_b0) rb0 <= ld_shift_b0 ? {1'b0, rb0[3:1]} : opb;
            if (en_p0) rp0 <= ld_add_p0 ? rp0 + ra0 : 8'd0;
        end
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            ra1 <= 8'd0; rb1 <= 4'd0; rp1 <= 8'd0;
        end else begin
            if (en_a1) ra1 <= ld_shift_a1 ? {ra1[6:0], 1'b0} : {4'd0, opa};
            if (en_b1) rb1 <= ld_shift_b1 ? {1'b0, rb1[3:1]} : opb;
            if (en_p1) rp1 <= ld_add_p1 ? rp1 + ra1 : 8'd0;
        end
    end

    function automatic int outs0();
        return int'({en_a0, ld_shift_a0, en_b0, ld_shift_b0, en_p0, ld_add_p0, busy0, done0, bit_cnt0});
    endfunction

    function automatic int outs1();
        return int'({en_a1, ld_shift_a1, en_b1, ld_shift_b1, en_p1, ld_add_p1, busy1, done1, bit_cnt1});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         p;      // product
        int         lat0;   // done latency, no early exit
        int         lat1;   // done latency, early exit
        int         cnt1;   // bit_cnt at done, early exit
        int         enp0;   // EVAL cycles with en_p high
    } vec_t;

    vec_t vecs[6];

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat0 = -1, lat1 = -1, p0v = -1, p1v = -1, c0 = -1, c1v = -1;
        int evals0 = 0, enp0 = 0, extra = 0, ba0 = -1, ba1 = -1;
        opa = v.a;
        opb = v.b;
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ld_add_p0) begin
                evals0++;
                if (en_p0) enp0++;
            end
            if (done0) begin
                if (lat0 < 0) begin lat0 = c; p0v = rp0; c0 = bit_cnt0; end
                else extra++;
            end
            if (done1) begin
                if (lat1 < 0) begin lat1 = c; p1v = rp1; c1v = bit_cnt1; end
                else extra++;
            end
            if (lat0 > 0 && c == lat0 + 1) ba0 = busy0;
            if (lat1 > 0 && c == lat1 + 1) ba1 = busy1;
        end
        check({tag, " latency ee0"}, lat0, v.lat0);
        check({tag, " latency ee1"}, lat1, v.lat1);
        check({tag, " product ee0"}, p0v, v.p);
        check({tag, " product ee1"}, p1v, v.p);
        check({tag, " bit_cnt ee0"}, c0, 4);
        check({tag, " bit_cnt ee1"}, c1v, v.cnt1);
        check({tag, " eval cycles ee0"}, evals0, 4);
        check({tag, " en_p in eval ee0"}, enp0, v.enp0);
        check({tag, " busy after done ee0"}, ba0, 0);
        check({tag, " busy after done ee1"}, ba1, 0);
        check({tag, " extra done pulses"}, extra, 0);
    endtask

    initial begin
        vecs[0] = '{a: 4'd5,  b: 4'd3,  p: 15,  lat0: 9, lat1: 5, cnt1: 2, enp0: 2};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 225, lat0: 9, lat1: 9, cnt1: 4, enp0: 4};
        vecs[2] = '{a: 4'd9,  b: 4'd0,  p: 0,   lat0: 9, lat1: 3, cnt1: 1, enp0: 0};
        vecs[3] = '{a: 4'd7,  b: 4'd1,  p: 7,   lat0: 9, lat1: 3, cnt1: 1, enp0: 1};
        vecs[4] = '{a: 4'd7,  b: 4'd8,  p: 56,  lat0: 9, lat1: 9, cnt1: 4, enp0: 1};
        vecs[5] = '{a: 4'd2,  b: 4'd6,  p: 12,  lat0: 9, lat1: 7, cnt1: 3, enp0: 2};

        clr = 1'b1; start = 1'b0; abort = 1'b0; opa = 4'd0; opb = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs ee0", outs0(), 0);
        check("reset outputs ee1", outs1(), 0);
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;
        check("idle busy after reset", int'({busy0, busy1}), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous clr during the second SHIFT
        begin
            int found = 0;
            opa = 4'd5; opb = 4'd3;
            pulse_start();
            for (int c = 0; c < 12 && found == 0; c++) begin
                @(posedge clk); #1;
                if (en_a0 && ld_shift_a0 && bit_cnt0 == 3'd1) found = 1;
            end
            check("clr test reached shift 2", found, 1);
            #1 clr = 1'b1;
            #1;
            check("clr mid-op outputs ee0", outs0(), 0);
            check("clr mid-op outputs ee1", outs1(), 0);
            @(negedge clk) clr = 1'b0;
            run_vec(vecs[0], "after clr");
        end

        // abort in the first EVAL
        begin
            int found = 0, dones = 0;
            opa = 4'd9; opb = 4'd5;
            pulse_start();
            for (int c = 0; c < 5 && found == 0; c++) begin
                @(posedge clk); #1;
                if (ld_add_p0) found = 1;
            end
            check("abort test reached eval", found, 1);
            abort = 1'b1;
            @(posedge clk); #1;
            check("busy after abort", int'({busy0, busy1}), 0);
            check("bit_cnt after abort", int'(bit_cnt0), 0);
            abort = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done0 || done1) dones++;
            end
            check("no done after abort", dones, 0);
        end

        // start held high: back-to-back multiplies
        begin
            int d0[2] = '{-1, -1};
            int d1[2] = '{-1, -1};
            int n0 = 0, n1 = 0, idle0 = 0, badp = 0;
            opa = 4'd2; opb = 4'd6;
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (done0 && n0 < 2) begin
                    d0[n0] = c; n0++;
                    if (rp0 != 8'd12) badp++;
                end
                if (done1 && n1 < 2) begin
                    d1[n1] = c; n1++;
                    if (rp1 != 8'd12) badp++;
                end
                if (n0 == 1 && !busy0) idle0++;
            end
            @(negedge clk) start = 1'b0;
            check("b2b first done ee0", d0[0], 9);
            check("b2b second done ee0", d0[1], 20);
            check("b2b first done ee1", d1[0], 7);
            check("b2b second done ee1", d1[1], 16);
            check("b2b idle cycles between ee0", idle0, 1);
            check("b2b wrong products", badp, 0);
            repeat (15) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
